// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one UART_TX among NUM_REQ byte sources
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int LAUNCH_TIMEOUT = 16,
  localparam int GID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            sent,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_en,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic [GID_W-1:0]              active_id,
  output logic                          arb_busy,
  output logic                          launch_err
);

  localparam int CNT_W = $clog2(LAUNCH_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t                  state_q, state_d;
  logic [GID_W-1:0]        ptr_q, ptr_d;
  logic [GID_W-1:0]        active_id_q, active_id_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_en_q, tx_en_d;
  logic                    arb_busy_q, arb_busy_d;
  logic                    launch_err_q, launch_err_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [NUM_REQ-1:0]      sent_q, sent_d;

  logic                    found_hi;
  logic [GID_W-1:0]        win_hi, win_lo, win;
  logic [DATA_WIDTH-1:0]   win_data;
  logic [NUM_REQ-1:0]      win_onehot, cur_onehot;
  logic [GID_W-1:0]        next_ptr;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        win_lo = GID_W'(j);
        if (GID_W'(j) >= ptr_q) begin
          win_hi   = GID_W'(j);
          found_hi = 1'b1;
        end
      end
    end
    win = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    win_data   = '0;
    win_onehot = '0;
    cur_onehot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (GID_W'(j) == win) begin
        win_data      = req_data[j*DATA_WIDTH +: DATA_WIDTH];
        win_onehot[j] = 1'b1;
      end
      if (GID_W'(j) == active_id_q) begin
        cur_onehot[j] = 1'b1;
      end
    end
  end

  assign next_ptr = (active_id_q == GID_W'(NUM_REQ - 1)) ? '0 : active_id_q + GID_W'(1);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    tx_en_d      = tx_en_q;
    active_id_d  = active_id_q;
    arb_busy_d   = arb_busy_q;
    ack_d        = '0;
    sent_d       = '0;
    launch_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req && !tx_busy) begin
          tx_data_d   = win_data;
          ack_d       = win_onehot;
          active_id_d = win;
          arb_busy_d  = 1'b1;
          tx_en_d     = 1'b1;
          cnt_d       = '0;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        // A done seen before busy still counts as a completed byte.
        if (tx_done) begin
          tx_en_d    = 1'b0;
          cnt_d      = '0;
          sent_d     = cur_onehot;
          ptr_d      = next_ptr;
          arb_busy_d = 1'b0;
          state_d    = IDLE;
        end else if (tx_busy) begin
          tx_en_d = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(LAUNCH_TIMEOUT - 1)) begin
          tx_en_d      = 1'b0;
          cnt_d        = '0;
          launch_err_d = 1'b1;
          arb_busy_d   = 1'b0;
          ptr_d        = next_ptr;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          sent_d     = cur_onehot;
          ptr_d      = next_ptr;
          arb_busy_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      tx_en_q      <= 1'b0;
      active_id_q  <= '0;
      arb_busy_q   <= 1'b0;
      launch_err_q <= 1'b0;
      ack_q        <= '0;
      sent_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      tx_en_q      <= tx_en_d;
      active_id_q  <= active_id_d;
      arb_busy_q   <= arb_busy_d;
      launch_err_q <= launch_err_d;
      ack_q        <= ack_d;
      sent_q       <= sent_d;
    end
  end

  assign ack        = ack_q;
  assign sent       = sent_q;
  assign tx_data    = tx_data_q;
  assign tx_en      = tx_en_q;
  assign active_id  = active_id_q;
  assign arb_busy   = arb_busy_q;
  assign launch_err = launch_err_q;

endmodule
